// File: rtl/audio_i2s_tx.sv
// I2S transmitter: latches one 11-bit stereo pair per 64-BCLK frame and shifts it out as 16-bit MSB-first words.
// All serial clocks come from clk; every output is registered and changes only on BCLK falling events.
module audio_i2s_tx #(
    parameter int BCLK_HALF = 7,
    parameter bit IN_SIGNED = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] in_left,
    input  logic [10:0] in_right,
    input  logic        mute,
    output logic        sample_strobe,
    output logic        i2s_bclk,
    output logic        i2s_lrclk,
    output logic        i2s_sdata
);
    localparam int DW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_HALF - 1);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          bclk_q, bclk_d;
    logic [5:0]    bit_cnt_q, bit_cnt_d;
    logic          lrclk_q, lrclk_d;
    logic          sdata_q, sdata_d;
    logic          strobe_q, strobe_d;
    logic [15:0]   hold_l_q, hold_l_d;
    logic [15:0]   hold_r_q, hold_r_d;

    logic          term;
    logic          fall;
    logic [5:0]    bit_next;
    logic [3:0]    bit_idx;

    function automatic logic [15:0] to_word(input logic [10:0] s);
        logic [10:0] t;
        t = IN_SIGNED ? s : (s ^ 11'h400);
        return {t, 5'b00000};
    endfunction

    always_comb begin
        term      = (div_cnt_q == DIV_LAST);
        fall      = term && bclk_q;
        div_cnt_d = term ? '0 : div_cnt_q + DW'(1);
        bclk_d    = term ? ~bclk_q : bclk_q;
        bit_next  = bit_cnt_q + 6'd1;
        // 16-n and 48-n reduce to the same index modulo 16
        bit_idx   = 4'd0 - bit_next[3:0];

        bit_cnt_d = bit_cnt_q;
        lrclk_d   = lrclk_q;
        sdata_d   = sdata_q;
        strobe_d  = 1'b0;
        hold_l_d  = hold_l_q;
        hold_r_d  = hold_r_q;

        if (fall) begin
            bit_cnt_d = bit_next;
            lrclk_d   = bit_next[5];
            if (bit_next == 6'd0) begin
                strobe_d = 1'b1;
                hold_l_d = mute ? 16'h0000 : to_word(in_left);
                hold_r_d = mute ? 16'h0000 : to_word(in_right);
            end
            // Bit 0 of each half is the I2S one-BCLK delay slot, so the hold
            // registers being refreshed at bit 0 is never visible on SDATA.
            if (bit_next >= 6'd1 && bit_next <= 6'd16)
                sdata_d = hold_l_q[bit_idx];
            else if (bit_next >= 6'd33 && bit_next <= 6'd48)
                sdata_d = hold_r_q[bit_idx];
            else
                sdata_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
            bclk_q    <= 1'b0;
            bit_cnt_q <= 6'd63;
            lrclk_q   <= 1'b0;
            sdata_q   <= 1'b0;
            strobe_q  <= 1'b0;
            hold_l_q  <= 16'h0000;
            hold_r_q  <= 16'h0000;
        end else begin
            div_cnt_q <= div_cnt_d;
            bclk_q    <= bclk_d;
            bit_cnt_q <= bit_cnt_d;
            lrclk_q   <= lrclk_d;
            sdata_q   <= sdata_d;
            strobe_q  <= strobe_d;
            hold_l_q  <= hold_l_d;
            hold_r_q  <= hold_r_d;
        end
    end

    assign sample_strobe = strobe_q;
    assign i2s_bclk      = bclk_q;
    assign i2s_lrclk     = lrclk_q;
    assign i2s_sdata     = sdata_q;
endmodule

// File: tb/tb_audio_i2s_tx.sv
// Directed bench for audio_i2s_tx at BCLK_HALF=2: clocking, conversion, isolation, mute and reset.
module tb_audio_i2s_tx;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] in_left = 11'h000;
    logic [10:0] in_right = 11'h000;
    logic        mute = 1'b0;

    logic sample_strobe, i2s_bclk, i2s_lrclk, i2s_sdata;
    logic s_strobe2, s_bclk2, s_lrclk2, s_sdata2;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] ZERO_MASK = 64'hFFFE0001_FFFE0001;

    audio_i2s_tx #(.BCLK_HALF(2), .IN_SIGNED(1'b0)) dut (
        .clk(clk), .rst(rst), .in_left(in_left), .in_right(in_right), .mute(mute),
        .sample_strobe(sample_strobe), .i2s_bclk(i2s_bclk),
        .i2s_lrclk(i2s_lrclk), .i2s_sdata(i2s_sdata)
    );

    audio_i2s_tx #(.BCLK_HALF(2), .IN_SIGNED(1'b1)) dut_s (
        .clk(clk), .rst(rst), .in_left(in_left), .in_right(in_right), .mute(mute),
        .sample_strobe(s_strobe2), .i2s_bclk(s_bclk2),
        .i2s_lrclk(s_lrclk2), .i2s_sdata(s_sdata2)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] word_of(input logic [63:0] b, input int base);
        logic [15:0] w;
        for (int i = 0; i < 16; i++) w[15-i] = b[base+i];
        return w;
    endfunction

    // Waits for a strobe, then samples SDATA/LRCLK once per bit slot (4 clks).
    // At slot chg_k the inputs are changed to chg_left/chg_mute.
    task automatic capture(input int chg_k, input logic [10:0] chg_left, input logic chg_mute,
                           output logic [63:0] b, output logic [63:0] b2,
                           output logic [63:0] lr, output bit ok);
        ok = 1'b0;
        b  = '0;
        b2 = '0;
        lr = '0;
        for (int i = 0; i < 600 && !ok; i++) begin
            @(negedge clk);
            if (sample_strobe === 1'b1) ok = 1'b1;
        end
        if (ok) begin
            for (int k = 0; k < 64; k++) begin
                if (k > 0) repeat (4) @(negedge clk);
                b[k]  = i2s_sdata;
                b2[k] = s_sdata2;
                lr[k] = i2s_lrclk;
                if (k == chg_k) begin
                    in_left = chg_left;
                    mute    = chg_mute;
                end
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if (i2s_bclk !== 1'b0) begin errors++; $display("FAIL reset_bclk got %b want 0", i2s_bclk); end
        checks++; if (i2s_lrclk !== 1'b0) begin errors++; $display("FAIL reset_lrclk got %b want 0", i2s_lrclk); end
        checks++; if (i2s_sdata !== 1'b0) begin errors++; $display("FAIL reset_sdata got %b want 0", i2s_sdata); end
        checks++; if (sample_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe got %b want 0", sample_strobe); end
    endtask

    // Releases rst and checks 260 clks of BCLK/LRCLK/strobe against a cycle model.
    task automatic test_clocking(input string tag);
        int bclk_err = 0, lr_err = 0, stb_err = 0;
        logic eb, el, es;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 260; c++) begin
            @(negedge clk);
            eb = ((c >> 1) & 1) == 1;
            el = (c >= 4) ? ((((c - 4) / 128) % 2) == 1) : 1'b0;
            es = (c == 4) || (c == 260);
            if (i2s_bclk !== eb) bclk_err++;
            if (i2s_lrclk !== el) lr_err++;
            if (sample_strobe !== es) stb_err++;
        end
        checks++; if (bclk_err != 0) begin errors++; $display("FAIL %s_bclk mismatched cycles %0d want 0", tag, bclk_err); end
        checks++; if (lr_err != 0) begin errors++; $display("FAIL %s_lrclk mismatched cycles %0d want 0", tag, lr_err); end
        checks++; if (stb_err != 0) begin errors++; $display("FAIL %s_strobe mismatched cycles %0d want 0", tag, stb_err); end
    endtask

    task automatic test_offset;
        logic [63:0] b, b2, lr;
        bit ok;
        logic [63:0] exp_lr;
        exp_lr = 64'hFFFFFFFF_00000000;
        in_left = 11'h7FF; in_right = 11'h000; mute = 1'b0;
        capture(-1, 11'h7FF, 1'b0, b, b2, lr, ok);
        checks++; if (!ok) begin errors++; $display("FAIL offset_timeout no strobe within bound"); end
        checks++; if (word_of(b, 1) !== 16'h7FE0) begin errors++; $display("FAIL offset_left got %h want 7fe0", word_of(b, 1)); end
        checks++; if (word_of(b, 33) !== 16'h8000) begin errors++; $display("FAIL offset_right got %h want 8000", word_of(b, 33)); end
        checks++; if ((b & ZERO_MASK) !== 64'h0) begin errors++; $display("FAIL offset_pad got %h want 0", b & ZERO_MASK); end
        checks++; if (lr !== exp_lr) begin errors++; $display("FAIL offset_lrclk got %h want %h", lr, exp_lr); end
    endtask

    task automatic test_midscale;
        logic [63:0] b, b2, lr;
        bit ok;
        in_left = 11'h400; in_right = 11'h400; mute = 1'b0;
        capture(-1, 11'h400, 1'b0, b, b2, lr, ok);
        checks++; if (!ok) begin errors++; $display("FAIL midscale_timeout no strobe within bound"); end
        checks++; if (word_of(b, 1) !== 16'h0000) begin errors++; $display("FAIL midscale_left got %h want 0000", word_of(b, 1)); end
        checks++; if (word_of(b, 33) !== 16'h0000) begin errors++; $display("FAIL midscale_right got %h want 0000", word_of(b, 33)); end
        checks++; if (word_of(b2, 1) !== 16'h8000) begin errors++; $display("FAIL signed_left got %h want 8000", word_of(b2, 1)); end
    endtask

    task automatic test_isolation;
        logic [63:0] b, b2, lr;
        bit ok;
        in_left = 11'h7FF; in_right = 11'h000; mute = 1'b0;
        capture(8, 11'h000, 1'b0, b, b2, lr, ok);
        checks++; if (!ok) begin errors++; $display("FAIL iso_timeout no strobe within bound"); end
        checks++; if (word_of(b, 1) !== 16'h7FE0) begin errors++; $display("FAIL iso_current got %h want 7fe0", word_of(b, 1)); end
        capture(-1, 11'h000, 1'b0, b, b2, lr, ok);
        checks++; if (word_of(b, 1) !== 16'h8000) begin errors++; $display("FAIL iso_next got %h want 8000", word_of(b, 1)); end
    endtask

    task automatic test_mute;
        logic [63:0] b, b2, lr;
        bit ok;
        in_left = 11'h7FF; in_right = 11'h000; mute = 1'b1;
        capture(-1, 11'h7FF, 1'b1, b, b2, lr, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mute_timeout no strobe within bound"); end
        checks++; if (b !== 64'h0) begin errors++; $display("FAIL mute_frame got %h want 0", b); end
        mute = 1'b0;
        capture(8, 11'h7FF, 1'b1, b, b2, lr, ok);
        checks++; if (word_of(b, 1) !== 16'h7FE0) begin errors++; $display("FAIL mute_resume got %h want 7fe0", word_of(b, 1)); end
        checks++; if (word_of(b, 33) !== 16'h8000) begin errors++; $display("FAIL mute_midframe got %h want 8000", word_of(b, 33)); end
        mute = 1'b0;
    endtask

    task automatic test_reset_mid;
        bit ok = 1'b0;
        in_left = 11'h7FF; in_right = 11'h000; mute = 1'b0;
        for (int i = 0; i < 600 && !ok; i++) begin
            @(negedge clk);
            if (sample_strobe === 1'b1) ok = 1'b1;
        end
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_timeout no strobe within bound"); end
        repeat (42) @(negedge clk);
        checks++; if (i2s_bclk !== 1'b1) begin errors++; $display("FAIL rstmid_pre_bclk got %b want 1", i2s_bclk); end
        checks++; if (i2s_sdata !== 1'b1) begin errors++; $display("FAIL rstmid_pre_sdata got %b want 1", i2s_sdata); end
        rst = 1'b1;
        #1;
        checks++; if (i2s_bclk !== 1'b0) begin errors++; $display("FAIL rstmid_bclk got %b want 0", i2s_bclk); end
        checks++; if (i2s_lrclk !== 1'b0) begin errors++; $display("FAIL rstmid_lrclk got %b want 0", i2s_lrclk); end
        checks++; if (i2s_sdata !== 1'b0) begin errors++; $display("FAIL rstmid_sdata got %b want 0", i2s_sdata); end
        repeat (3) @(negedge clk);
        checks++; if (sample_strobe !== 1'b0) begin errors++; $display("FAIL rstmid_strobe got %b want 0", sample_strobe); end
        test_clocking("after_reset");
    endtask

    initial begin
        test_reset();
        test_clocking("startup");
        test_offset();
        test_midscale();
        test_isolation();
        test_mute();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
